// File: rtl/ccff_chain_loader.sv
// Purpose: loads one ccff configuration chain LSB-first from a word stream, then recirculates it once to verify.
// Latency: done pulses 1 + ceil(CHAIN_LEN/WORD_W) + 2*CHAIN_LEN + 1 cycles after start, counting the start cycle.
// Backpressure: word_ready only in LOAD; the chain clock is gated off while waiting, so stalls are lossless.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WORD_W-1:0]  shreg;
    logic [CHAIN_LEN-1:0] golden;
    logic [WB_W-1:0]    word_bit;
    logic               last_chain_bit;
    logic               last_word_bit;

    assign last_chain_bit = (bit_count == CNT_W'(CHAIN_LEN - 1));
    assign last_word_bit  = (word_bit == WB_W'(WORD_W - 1));

    // State register; reset drops straight back to IDLE, which also kills the chain clock.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; in VERIFY the tail is looped back to the head so contents survive.
    always_comb begin
        state_nxt   = state;
        word_ready  = 1'b0;
        ccff_clk_en = 1'b0;
        ccff_head   = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                word_ready = 1'b1;
                if (word_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                ccff_clk_en = 1'b1;
                ccff_head   = shreg[0];
                if (last_chain_bit) begin
                    state_nxt = VERIFY;
                end else if (last_word_bit) begin
                    state_nxt = LOAD;
                end
            end
            VERIFY: begin
                ccff_clk_en = 1'b1;
                ccff_head   = ccff_tail;
                if (last_chain_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word capture, serializer, golden copy and readback compare.
    // golden fills from the top so that after CHAIN_LEN shifts golden[k] holds chain bit k;
    // during VERIFY it rotates so golden[0] always lines up with the bit now on ccff_tail.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            shreg      <= '0;
            golden     <= '0;
            word_bit   <= '0;
            bit_count  <= '0;
            verify_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        verify_err <= 1'b0;
                        bit_count  <= '0;
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        shreg    <= word_in;
                        word_bit <= '0;
                    end
                end
                SHIFT: begin
                    shreg     <= shreg >> 1;
                    golden    <= {shreg[0], golden[CHAIN_LEN-1:1]};
                    word_bit  <= word_bit + WB_W'(1);
                    bit_count <= last_chain_bit ? '0 : bit_count + CNT_W'(1);
                end
                VERIFY: begin
                    if (ccff_tail != golden[0]) verify_err <= 1'b1;
                    golden    <= {golden[0], golden[CHAIN_LEN-1:1]};
                    bit_count <= last_chain_bit ? '0 : bit_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Programming controller for one configuration chain of connection-block/switch-block mux memories, linked ccff_head to ccff_tail.
- Accepts bitstream words over a valid/ready stream and serializes them LSB-first into the chain.
- Then recirculates the chain once to read back and check every bit, leaving the contents unchanged.
- Sits between the bitstream source and the first ccff_head of a tile column; its ccff_clk_en gates the chain clock.

Parameters:
CHAIN_LEN, 8, total configuration bits in the chain (e.g. 3+2+3 for one cbx).
WORD_W, 8, width of incoming bitstream words.
CNT_W, $clog2(CHAIN_LEN+1), width of bit counter.

Ports:
prog_clk  in  1  programming clock.
prog_reset  in  1  asynchronous active-high reset.
start  in  1  one-cycle pulse, begins a load; ignored while busy.
word_in  in  WORD_W  bitstream word; bit 0 is shifted first.
word_valid  in  1  word_in valid.
word_ready  out  1  word accepted on a cycle where word_valid && word_ready.
ccff_head  out  1  serial data into the chain.
ccff_tail  in  1  serial data out of the last chain flop.
ccff_clk_en  out  1  chain flops advance on prog_clk edges where this is 1.
busy  out  1  high from the cycle after start until done.
done  out  1  one-cycle pulse at completion.
verify_err  out  1  sticky readback mismatch; cleared by the next accepted start.
bit_count  out  CNT_W  bits shifted in the current phase.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register, golden register and counters 0. Reset is asynchronous.
- States: IDLE, LOAD, SHIFT, VERIFY, DONE.
- IDLE: start=1 -> LOAD; clears verify_err and bit_count.
- LOAD: word_ready=1, ccff_clk_en=0.
  - On word_valid: capture word_in into shift register, clear word bit index, go to SHIFT.
  - Stalls are safe because the chain does not advance.
- SHIFT: ccff_clk_en=1 and ccff_head=shreg[0] every cycle, both from registers.
  - Each cycle: shreg shifts right; golden[bit_count] <= shreg[0]; bit_count++.
  - When bit_count reaches CHAIN_LEN: bit_count <= 0, go to VERIFY. Any remaining bits of the current word are discarded.
  - Else, when WORD_W bits of the word are consumed: go to LOAD.
- VERIFY: ccff_clk_en=1; ccff_head = ccff_tail (combinational recirculation).
  - In VERIFY cycle k, compare ccff_tail against golden[k]; on mismatch set verify_err.
  - After CHAIN_LEN cycles, go to DONE. The chain then holds the loaded contents again.
- DONE: done=1 for one cycle, ccff_clk_en=0, then IDLE.
- busy = (state != IDLE).
- A start pulse while busy has no effect.
- prog_reset mid-operation: return to IDLE immediately; ccff_clk_en drops to 0; no done pulse; chain contents are undefined.
- Latency with no stalls: done is asserted 1 + ceil(CHAIN_LEN/WORD_W)·1 + 2·CHAIN_LEN + 1 cycles after start (one LOAD cycle per word).

Test Plan:
- CHAIN_LEN=8, WORD_W=8, word 0xA5 valid at start:
  - ccff_head over the 8 SHIFT cycles reads 1,0,1,0,0,1,0,1.
  - Bench chain model holds 0xA5; done asserted 19 cycles after start.
  - verify_err=0; model still holds 0xA5 after VERIFY.
- CHAIN_LEN=12, WORD_W=8, words 0x3C then 0xF9:
  - 12 bits shifted: 0x3C LSB-first, then 0x9 LSB-first (1,0,0,1).
  - Upper nibble of 0xF9 never appears on ccff_head.
  - Two word_ready handshakes; done asserted; verify_err=0.
- Backpressure: word_valid low for 5 cycles between the two words:
  - ccff_clk_en stays 0 during the stall.
  - Final chain contents are identical to the no-stall run.
- Fault injection: bench forces model chain bit 3 to toggle before VERIFY:
  - verify_err goes to 1 and stays 1 after done.
  - The next start clears verify_err.
- prog_reset pulsed during SHIFT cycle 4:
  - All outputs read 0 the same cycle; no done pulse.
  - A fresh start then loads correctly.
- start pulsed during VERIFY: ignored; exactly one done pulse; busy stays high continuously until done.
